// File: rtl/mmu_cfg_ctrl_pkg.sv
// rtl/mmu_cfg_ctrl_pkg.sv - shared types and constants for the MMU configuration sequencer
//   mmu_cfg_reg_e    : register indices on cfg_addr_i
//   mmu_cfg_state_e  : sequencer states
//   privilegeLevel_e : core privilege encoding
//   ST_*             : STATUS register bit positions
package mmu_cfg_ctrl_pkg;

    typedef enum logic [2:0] {
        REG_MASK       = 3'd0,
        REG_OFFSET     = 3'd1,
        REG_SIZE       = 3'd2,
        REG_CTRL       = 3'd3,
        REG_STATUS     = 3'd4,
        REG_FAULT_ADDR = 3'd5,
        REG_RSVD6      = 3'd6,
        REG_RSVD7      = 3'd7
    } mmu_cfg_reg_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_COMMIT = 2'd2
    } mmu_cfg_state_e;

    typedef enum logic [1:0] {
        USER       = 2'b00,
        SUPERVISOR = 2'b01,
        MACHINE    = 2'b11
    } privilegeLevel_e;

    localparam int ST_BUSY    = 0;
    localparam int ST_TIMEOUT = 1;
    localparam int ST_WR_DROP = 2;
    localparam int ST_FAULT   = 3;

    localparam logic [31:0] MASK_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/mmu_cfg_ctrl.sv
// rtl/mmu_cfg_ctrl.sv - shadow/active MMU configuration sequencer with drain-and-commit
//   clk, reset_n          : clock, asynchronous active-low reset
//   cfg_we_i/addr/wdata   : register write port; cfg_rdata_o is combinational from cfg_addr_i
//   privilege_i           : current privilege, gates mmu_en_o
//   mem_busy_i            : outstanding memory traffic, must fall before a commit
//   fault_i/fault_addr_i  : MMU fault report, first one captured
//   stall_o               : holds fetch/issue while a commit is in progress
//   mmu_en_o/mask/offset/size : active configuration driven to the MMU
module mmu_cfg_ctrl
    import mmu_cfg_ctrl_pkg::*;
#(
    parameter int DRAIN_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_we_i,
    input  logic [2:0]  cfg_addr_i,
    input  logic [31:0] cfg_wdata_i,
    output logic [31:0] cfg_rdata_o,
    input  logic [1:0]  privilege_i,
    input  logic        mem_busy_i,
    input  logic        fault_i,
    input  logic [31:0] fault_addr_i,
    output logic        stall_o,
    output logic        mmu_en_o,
    output logic [31:0] mmu_mask_o,
    output logic [31:0] mmu_offset_o,
    output logic [31:0] mmu_size_o
);

    localparam int              CNT_W    = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

    mmu_cfg_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      sh_mask_q, sh_mask_d, sh_offset_q, sh_offset_d, sh_size_q, sh_size_d;
    logic             sh_en_q, sh_en_d;
    logic [31:0]      act_mask_q, act_mask_d, act_offset_q, act_offset_d, act_size_q, act_size_d;
    logic             act_en_q, act_en_d;
    logic             timeout_q, timeout_d, wr_drop_q, wr_drop_d, fault_valid_q, fault_valid_d;
    logic [31:0]      fault_addr_q, fault_addr_d;

    mmu_cfg_reg_e reg_sel;
    logic         busy, cfg_wr, status_wr;

    assign reg_sel   = mmu_cfg_reg_e'(cfg_addr_i);
    assign busy      = (state_q != ST_IDLE);
    assign cfg_wr    = cfg_we_i && (reg_sel == REG_MASK || reg_sel == REG_OFFSET ||
                                    reg_sel == REG_SIZE || reg_sel == REG_CTRL);
    assign status_wr = cfg_we_i && (reg_sel == REG_STATUS);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sh_mask_d     = sh_mask_q;
        sh_offset_d   = sh_offset_q;
        sh_size_d     = sh_size_q;
        sh_en_d       = sh_en_q;
        act_mask_d    = act_mask_q;
        act_offset_d  = act_offset_q;
        act_size_d    = act_size_q;
        act_en_d      = act_en_q;
        timeout_d     = timeout_q;
        wr_drop_d     = wr_drop_q;
        fault_valid_d = fault_valid_q;
        fault_addr_d  = fault_addr_q;

        // W1C first so that hardware sets further down take priority
        if (status_wr) begin
            if (cfg_wdata_i[ST_TIMEOUT]) timeout_d     = 1'b0;
            if (cfg_wdata_i[ST_WR_DROP]) wr_drop_d     = 1'b0;
            if (cfg_wdata_i[ST_FAULT])   fault_valid_d = 1'b0;
        end

        // A fault arriving in the same cycle as its W1C is captured as a fresh fault
        if (fault_i && !fault_valid_d) begin
            fault_valid_d = 1'b1;
            fault_addr_d  = fault_addr_i;
        end

        if (cfg_wr) begin
            if (busy) begin
                wr_drop_d = 1'b1;
            end else begin
                case (reg_sel)
                    REG_MASK:   sh_mask_d   = cfg_wdata_i;
                    REG_OFFSET: sh_offset_d = cfg_wdata_i;
                    REG_SIZE:   sh_size_d   = cfg_wdata_i;
                    default: begin
                        sh_en_d = cfg_wdata_i[0];
                        if (cfg_wdata_i[1]) begin
                            state_d = ST_DRAIN;
                            cnt_d   = '0;
                        end
                    end
                endcase
            end
        end

        case (state_q)
            ST_DRAIN: begin
                if (!mem_busy_i) begin
                    state_d = ST_COMMIT;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_COMMIT: begin
                act_mask_d   = sh_mask_q;
                act_offset_d = sh_offset_q;
                act_size_d   = sh_size_q;
                act_en_d     = sh_en_q;
                state_d      = ST_IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            sh_mask_q     <= MASK_RST;
            sh_offset_q   <= '0;
            sh_size_q     <= '0;
            sh_en_q       <= 1'b0;
            act_mask_q    <= MASK_RST;
            act_offset_q  <= '0;
            act_size_q    <= '0;
            act_en_q      <= 1'b0;
            timeout_q     <= 1'b0;
            wr_drop_q     <= 1'b0;
            fault_valid_q <= 1'b0;
            fault_addr_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sh_mask_q     <= sh_mask_d;
            sh_offset_q   <= sh_offset_d;
            sh_size_q     <= sh_size_d;
            sh_en_q       <= sh_en_d;
            act_mask_q    <= act_mask_d;
            act_offset_q  <= act_offset_d;
            act_size_q    <= act_size_d;
            act_en_q      <= act_en_d;
            timeout_q     <= timeout_d;
            wr_drop_q     <= wr_drop_d;
            fault_valid_q <= fault_valid_d;
            fault_addr_q  <= fault_addr_d;
        end
    end

    always_comb begin
        cfg_rdata_o = '0;
        case (reg_sel)
            REG_MASK:       cfg_rdata_o = sh_mask_q;
            REG_OFFSET:     cfg_rdata_o = sh_offset_q;
            REG_SIZE:       cfg_rdata_o = sh_size_q;
            REG_CTRL:       cfg_rdata_o = {31'b0, sh_en_q};
            REG_STATUS:     cfg_rdata_o = {28'b0, fault_valid_q, wr_drop_q, timeout_q, busy};
            REG_FAULT_ADDR: cfg_rdata_o = fault_addr_q;
            default:        cfg_rdata_o = '0;
        endcase
    end

    assign stall_o      = busy;
    assign mmu_en_o     = act_en_q && (privilegeLevel_e'(privilege_i) == USER);
    assign mmu_mask_o   = act_mask_q;
    assign mmu_offset_o = act_offset_q;
    assign mmu_size_o   = act_size_q;

endmodule

// File: tb/tb_mmu_cfg_ctrl.sv
// tb/tb_mmu_cfg_ctrl.sv - self-checking bench for mmu_cfg_ctrl
module tb_mmu_cfg_ctrl;
    import mmu_cfg_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_we_i;
    logic [2:0]  cfg_addr_i;
    logic [31:0] cfg_wdata_i;
    logic [31:0] cfg_rdata_o;
    logic [1:0]  privilege_i;
    logic        mem_busy_i;
    logic        fault_i;
    logic [31:0] fault_addr_i;
    logic        stall_o;
    logic        mmu_en_o;
    logic [31:0] mmu_mask_o;
    logic [31:0] mmu_offset_o;
    logic [31:0] mmu_size_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    mmu_cfg_ctrl #(.DRAIN_TIMEOUT(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg_we_i     (cfg_we_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_wdata_i  (cfg_wdata_i),
        .cfg_rdata_o  (cfg_rdata_o),
        .privilege_i  (privilege_i),
        .mem_busy_i   (mem_busy_i),
        .fault_i      (fault_i),
        .fault_addr_i (fault_addr_i),
        .stall_o      (stall_o),
        .mmu_en_o     (mmu_en_o),
        .mmu_mask_o   (mmu_mask_o),
        .mmu_offset_o (mmu_offset_o),
        .mmu_size_o   (mmu_size_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic [31:0] got);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_val(e.tag, got, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] data);
        cfg_we_i    = 1'b1;
        cfg_addr_i  = addr;
        cfg_wdata_i = data;
        tick();
        cfg_we_i    = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        push_exp(tag, exp);
        cfg_addr_i = addr;
        #1;
        observe(cfg_rdata_o);
    endtask

    task automatic out_chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        push_exp(tag, exp);
        observe(got);
    endtask

    task automatic reset_regs_chk(input string pfx);
        logic [31:0] rst_vals [8];
        rst_vals = '{32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            rd_chk($sformatf("%s_reg%0d", pfx, i), 3'(i), rst_vals[i]);
        end
        out_chk({pfx, "_en"}, {31'b0, mmu_en_o}, 32'd0);
        out_chk({pfx, "_stall"}, {31'b0, stall_o}, 32'd0);
        out_chk({pfx, "_mask_o"}, mmu_mask_o, 32'hFFFF_FFFF);
        out_chk({pfx, "_offset_o"}, mmu_offset_o, 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (stall_o && n < 20) begin
            tick();
            n++;
        end
        out_chk(tag, {31'b0, stall_o}, 32'd0);
    endtask

    initial begin
        int n;
        reset_n      = 1'b0;
        cfg_we_i     = 1'b0;
        cfg_addr_i   = '0;
        cfg_wdata_i  = '0;
        privilege_i  = USER;
        mem_busy_i   = 1'b0;
        fault_i      = 1'b0;
        fault_addr_i = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // 1: reset values
        reset_regs_chk("rst");

        // 2: best-case commit
        wr(REG_MASK, 32'h0000_0FFF);
        wr(REG_OFFSET, 32'h0001_0000);
        wr(REG_SIZE, 32'h0);
        wr(REG_CTRL, 32'h3);
        out_chk("c2_stall_t1", {31'b0, stall_o}, 32'd1);
        rd_chk("c2_status_busy", REG_STATUS, 32'h1);
        out_chk("c2_offset_t1_old", mmu_offset_o, 32'd0);
        tick();
        out_chk("c2_stall_t2", {31'b0, stall_o}, 32'd1);
        tick();
        out_chk("c2_stall_t3", {31'b0, stall_o}, 32'd0);
        out_chk("c2_offset_t3", mmu_offset_o, 32'h0001_0000);
        out_chk("c2_mask_t3", mmu_mask_o, 32'h0000_0FFF);
        out_chk("c2_en_user", {31'b0, mmu_en_o}, 32'd1);
        privilege_i = MACHINE;
        #1;
        out_chk("c2_en_machine", {31'b0, mmu_en_o}, 32'd0);
        privilege_i = USER;
        #1;

        // 3a: drain timeout with busy held
        wr(REG_OFFSET, 32'h0000_2000);
        mem_busy_i = 1'b1;
        wr(REG_CTRL, 32'h3);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!stall_o) break;
            n++;
            tick();
        end
        out_chk("c3_drain_cycles", n, 32'd4);
        rd_chk("c3_status_timeout", REG_STATUS, 32'h2);
        out_chk("c3_offset_unchanged", mmu_offset_o, 32'h0001_0000);
        wr(REG_STATUS, 32'h2);
        rd_chk("c3_status_cleared", REG_STATUS, 32'h0);

        // 3b: busy falls after two drain cycles
        wr(REG_CTRL, 32'h3);
        tick();
        mem_busy_i = 1'b0;
        tick();
        out_chk("c3b_commit_stall", {31'b0, stall_o}, 32'd1);
        tick();
        out_chk("c3b_stall_done", {31'b0, stall_o}, 32'd0);
        out_chk("c3b_offset_new", mmu_offset_o, 32'h0000_2000);
        rd_chk("c3b_status_clean", REG_STATUS, 32'h0);

        // 4: write dropped while busy
        mem_busy_i = 1'b1;
        wr(REG_CTRL, 32'h3);
        wr(REG_OFFSET, 32'h0000_5555);
        rd_chk("c4_shadow_kept", REG_OFFSET, 32'h0000_2000);
        rd_chk("c4_status_drop", REG_STATUS, 32'h5);
        mem_busy_i = 1'b0;
        wait_idle("c4_idle");
        rd_chk("c4_status_after", REG_STATUS, 32'h4);
        wr(REG_STATUS, 32'h4);
        rd_chk("c4_status_w1c", REG_STATUS, 32'h0);

        // 5: fault capture
        fault_i      = 1'b1;
        fault_addr_i = 32'h0000_8000;
        tick();
        fault_addr_i = 32'h0000_9000;
        tick();
        fault_i = 1'b0;
        rd_chk("c5_fault_first", REG_FAULT_ADDR, 32'h0000_8000);
        rd_chk("c5_status_fault", REG_STATUS, 32'h8);
        fault_i      = 1'b1;
        fault_addr_i = 32'h0000_A000;
        wr(REG_STATUS, 32'h8);
        fault_i = 1'b0;
        rd_chk("c5_fault_recap", REG_FAULT_ADDR, 32'h0000_A000);
        rd_chk("c5_status_still", REG_STATUS, 32'h8);

        // 6: async reset mid-drain
        wr(REG_OFFSET, 32'h0000_0003);
        mem_busy_i = 1'b1;
        wr(REG_CTRL, 32'h3);
        tick();
        out_chk("c6_in_drain", {31'b0, stall_o}, 32'd1);
        reset_n = 1'b0;
        #1;
        reset_regs_chk("c6");
        mem_busy_i = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        out_chk("c6_after_release", {31'b0, stall_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
